// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: ROM read port, decode handshake and execute-stage control.
// The master modport is the fetch unit's view; the slave modport is the surrounding pipeline's view.
interface instr_fetch_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
);
  logic [ADDR_BITS-1:0]   rom_addr;
  logic [2*DATA_BITS-1:0] rom_data;
  logic [2*DATA_BITS-1:0] instr_out;
  logic [ADDR_BITS-1:0]   pc_out;
  logic                   instr_valid;
  logic                   instr_ready;
  logic                   redirect;
  logic [ADDR_BITS-1:0]   redirect_addr;
  logic                   halt;
  logic                   halted;

  modport master (
    output rom_addr, instr_out, pc_out, instr_valid, halted,
    input  rom_data, instr_ready, redirect, redirect_addr, halt
  );

  modport slave (
    input  rom_addr, instr_out, pc_out, instr_valid, halted,
    output rom_data, instr_ready, redirect, redirect_addr, halt
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: walks the program ROM into a 2-entry prefetch FIFO and
// hands instructions to decode over valid/ready, with redirect and halt control.
//
// state | meaning
// RUN   | fetching one ROM word per cycle while the buffer has room
// HALT  | fetch frozen; buffered entries still drain; only redirect or rst leaves
module instr_fetch_unit #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter logic [ADDR_BITS-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);
  localparam int IW = 2 * DATA_BITS;

  typedef enum logic {RUN, HALT} state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] ent0_pc_q, ent0_pc_d, ent1_pc_q, ent1_pc_d;
  logic [IW-1:0]        ent0_ins_q, ent0_ins_d, ent1_ins_q, ent1_ins_d;
  logic                 valid_q, valid_d;
  logic                 halted_q, halted_d;
  logic                 pop, push;

  always_comb begin
    pop  = valid_q & bus.instr_ready;
    push = (state_q == RUN) & ~bus.redirect & ~bus.halt & ((cnt_q != 2'd2) | pop);

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    cnt_d      = cnt_q;
    ent0_pc_d  = ent0_pc_q;
    ent0_ins_d = ent0_ins_q;
    ent1_pc_d  = ent1_pc_q;
    ent1_ins_d = ent1_ins_q;

    if (bus.redirect) begin
      // Flush only drops the count; the head registers keep their last values.
      cnt_d      = 2'd0;
      fetch_pc_d = bus.redirect_addr;
      state_d    = RUN;
    end else begin
      if (bus.halt) state_d = HALT;
      if (push) fetch_pc_d = fetch_pc_q + ADDR_BITS'(1);
      // Entry 0 is always the head; it only shifts when a younger entry exists.
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            ent0_pc_d  = fetch_pc_q;
            ent0_ins_d = bus.rom_data;
          end else begin
            ent1_pc_d  = fetch_pc_q;
            ent1_ins_d = bus.rom_data;
          end
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          if (cnt_q == 2'd2) begin
            ent0_pc_d  = ent1_pc_q;
            ent0_ins_d = ent1_ins_q;
          end
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd2) begin
            ent0_pc_d  = ent1_pc_q;
            ent0_ins_d = ent1_ins_q;
            ent1_pc_d  = fetch_pc_q;
            ent1_ins_d = bus.rom_data;
          end else begin
            ent0_pc_d  = fetch_pc_q;
            ent0_ins_d = bus.rom_data;
          end
        end
        default: ;
      endcase
    end

    valid_d  = (cnt_d != 2'd0);
    halted_d = (state_d == HALT) & (cnt_d == 2'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      cnt_q      <= 2'd0;
      ent0_pc_q  <= '0;
      ent0_ins_q <= '0;
      ent1_pc_q  <= '0;
      ent1_ins_q <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      cnt_q      <= cnt_d;
      ent0_pc_q  <= ent0_pc_d;
      ent0_ins_q <= ent0_ins_d;
      ent1_pc_q  <= ent1_pc_d;
      ent1_ins_q <= ent1_ins_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.rom_addr    = fetch_pc_q;
  assign bus.instr_out   = ent0_ins_q;
  assign bus.pc_out      = ent0_pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted      = halted_q;
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Sequences the program ROM: owns the fetch program counter and drives the ROM read address.
- Captures the 2*DATA_BITS-wide instruction words into a 2-entry prefetch buffer.
- Presents instructions to the decoder over a valid/ready handshake.
- Accepts branch/jump redirects and a halt request from the execute stage; sits between the ROM and the decode stage.

Parameters:
- ADDR_BITS, 8, ROM address width; also the PC width.
- DATA_BITS, 8, data word width; the instruction width is 2*DATA_BITS.
- RESET_PC, 0, fetch address loaded on reset (ADDR_BITS wide).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rom_addr  out  ADDR_BITS  ROM read address; equals fetch_pc combinationally.
- rom_data  in  2*DATA_BITS  ROM read data; combinational, valid in the same cycle as rom_addr.
- instr_out  out  2*DATA_BITS  instruction at the buffer head.
- pc_out  out  ADDR_BITS  ROM address from which instr_out was fetched.
- instr_valid  out  1  buffer head holds a valid instruction.
- instr_ready  in  1  decoder accepts instr_out this cycle.
- redirect  in  1  one-cycle pulse: flush and restart fetch at redirect_addr.
- redirect_addr  in  ADDR_BITS  new fetch address, sampled when redirect=1.
- halt  in  1  stop fetching (level or pulse).
- halted  out  1  fetch stopped and buffer drained.

Behaviour:

Reset (while rst=1):
- fetch_pc=RESET_PC, buffer count=0, state=RUN.
- instr_valid=0, halted=0, instr_out=0, pc_out=0.
- Asserting rst mid-operation discards all buffered entries immediately (asynchronous).

State and storage:
- States: RUN (fetching) and HALT (not fetching).
- Buffer: 2-entry FIFO of {pc, instr}. count ranges 0..2.
- instr_out, pc_out and instr_valid come directly from registers or the head entry. There is no combinational path from rom_data to instr_out.
- With count=0, instr_out and pc_out hold their last values (0 after reset).

Pop and push:
- pop = instr_valid & instr_ready.
- push = (state==RUN) & ~redirect & ~halt & (count<2 | pop).
- On push: write {fetch_pc, rom_data} to the tail, then fetch_pc <= fetch_pc+1 modulo 2^ADDR_BITS (2^ADDR_BITS-1 wraps to 0).
- Simultaneous push and pop with count=2 or count=1: count is unchanged and order is preserved.

Latency:
- The first instruction is valid 1 cycle after rst deasserts: it is pushed on the first edge and instr_valid=1 after that edge.
- Sustained throughput is 1 instruction per cycle while instr_ready=1.

Backpressure:
- With instr_ready=0, the buffer fills to 2 and fetch_pc stops advancing.
- instr_out and pc_out stay stable while instr_valid=1 & instr_ready=0.

Redirect (highest priority below reset):
- On the edge with redirect=1: buffer flushed (count=0, any pop in that cycle is ignored), no push, fetch_pc <= redirect_addr, state <= RUN.
- Redirect from HALT resumes fetching.
- instr_valid=0 for exactly 1 cycle after the redirect edge.
- The instruction at redirect_addr is valid on the following cycle.

Halt:
- halt=1 with no redirect: state <= HALT and push is suppressed from that cycle on.
- Buffered entries still drain normally.
- halted = (state==HALT) & (count==0), registered so it is valid after the edge that empties the buffer.
- In HALT, fetch_pc is frozen; deasserting halt does not resume fetching, only redirect or rst does.
- redirect and halt in the same cycle: the redirect is applied and halt is ignored that cycle.

Test Plan:
1. ROM mem[i]=16'h0101*i, RESET_PC=0, instr_ready=1 from reset -> instr_valid=1 one cycle after rst falls; successive cycles show pc_out=0,1,2,3 and instr_out=0000,0101,0202,0303.
2. Backpressure: stream, then drop instr_ready for 5 cycles at pc_out=4 -> instr_out stays 0404 and count reaches 2; on release, 0404 and 0505 are accepted back-to-back, then 0606, with no loss or duplication.
3. Redirect: pulse redirect with redirect_addr=8'h40 while the buffer is full -> instr_valid=0 for one cycle, then pc_out=40 and instr_out=4040, then 41; stale entries never appear.
4. Wrap: redirect to 8'hFE -> pc_out sequence FE, FF, 00, 01.
5. Halt: assert halt at pc 10 with instr_ready=0 and 2 entries buffered, then raise instr_ready -> 2 entries drain, halted=1 the cycle after the last pop, instr_valid=0. A later redirect to 8'h20 clears halted and resumes at 20.
6. Simultaneous redirect and halt to 8'h30 -> fetching resumes at 30 and halted stays 0. Then assert rst mid-stream -> instr_valid drops immediately; after release, pc_out restarts at RESET_PC.
